pattern_match: RTL and testbench
================================

# pattern_match

Parametrised, case-folding string detector for the character-stream datapath. Accepts one 8-bit ASCII character per `in_valid` cycle, compares the most recent characters against a run-time-loadable pattern of up to `MAXLEN` characters, and pulses `match` for each occurrence, overlapping ones included. It also keeps a saturating occurrence count. It is the programmable, multi-length generalisation of the fixed-word detectors already in the design.

## Interface
- `MAXLEN`, 8: maximum pattern length in characters; must be ≥ 1.
- `CNT_W`, 16: width of the occurrence counter.
- `CASE_INS`, 1: 1 means letters A–Z and a–z compare equal to their other case; 0 means exact byte compare.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `char` is presented this cycle.
- `char`  in  8  ASCII input character.
- `cfg_we`  in  1  write `cfg_char` into pattern slot `cfg_idx`.
- `cfg_idx`  in  $clog2(MAXLEN)  pattern slot; slot 0 is the first character of the pattern.
- `cfg_char`  in  8  pattern character.
- `len_we`  in  1  load `cfg_len` as the active pattern length.
- `cfg_len`  in  $clog2(MAXLEN+1)  pattern length, 0..MAXLEN.
- `cnt_clr`  in  1  clear `match_cnt`.
- `match`  out  1  registered one-cycle pulse; an occurrence ended on the previous accepted character.
- `match_cnt`  out  CNT_W  saturating occurrence count.

## Operation
- State:
  - `pat[MAXLEN]`: pattern, stored already case-folded when `CASE_INS=1`.
  - `len`: active pattern length.
  - `hist[MAXLEN]`: shift register of the last accepted characters, folded.
  - `fill`: valid-history count, saturates at MAXLEN.
  - `match`, `match_cnt`.
- Fold: when `CASE_INS=1`, bytes 0x41–0x5A become 0x61–0x7A; all other bytes pass unchanged.
- Accept (`in_valid=1`, no config write this cycle):
  - `hist` shifts by one and the folded `char` enters at position 0 (newest).
  - `fill` increments, saturating at MAXLEN.
- Hit: on an accepting edge, a hit occurs iff all of the following hold:
  - `len ≠ 0`;
  - `fill_next ≥ len`;
  - for every i < len, new-history position i equals `pat[len-1-i]`.
- Overlapping occurrences are detected naturally; there is no state reset after a hit.
- On a hit:
  - `match` is set to 1 for one cycle; otherwise `match` is 0 on every edge.
  - `match_cnt` increments unless it is all-ones (saturates).
- Config write (`cfg_we` or `len_we`): updates the pattern or length, then clears `hist`/`fill` and forces `match` to 0.
  - Any `in_valid` character in the same cycle is discarded.
  - A `len_we` with `cfg_len > MAXLEN` is ignored entirely, including the clears.
- `cnt_clr`: sets `match_cnt` to 0 and takes priority over a same-cycle increment. `match` still pulses.
- Reset:
  - `match=0`, `match_cnt=0`, `fill=0`, `hist` all 0x00, `len=0`, `pat` all 0x00.
  - With `len=0` the block never matches until configured.
  - Reset mid-stream discards any partial occurrence.

## Timing
- Latency: the character completing an occurrence is accepted on edge k, and `match=1` for the cycle between edges k and k+1.
- Back-to-back hits (e.g. pattern "aa" on "aaa") give `match` high on consecutive cycles.
- Idle cycles (`in_valid=0`) do not disturb `hist`; a pattern may straddle gaps. `match` returns to 0 on the first idle edge.
- Config takes effect for characters accepted on the edge after the write edge.
- `match_cnt` updates on the same edge as `match`.
- Priority per edge: `reset` > config write > accept.

## Structure
- Shared package `pm_pkg` holds:
  - `char_t` (8-bit);
  - constants `ASCII_UC_A`/`ASCII_UC_Z`/`ASCII_CASE_OFF`;
  - a pure `fold_char(char_t, bit case_ins)` function.
- One sub-module, `pm_compare`: combinational, parameterised by MAXLEN. It takes `hist_next`, `pat`, `len` and `fill_next`, and returns `hit`.
- Top level holds the registers, config and priority logic.

## Test plan
- Case-insensitive match: load "csCore" with len=6, `CASE_INS=1`; feed "xCSCORE" → `match` one cycle after 'E', `match_cnt=1`.
- Overlap: pattern "aba" with len=3; feed "ababa" → `match` after the 3rd and 5th characters, `match_cnt=2`.
- Exact compare and gaps: `CASE_INS=0`, pattern "Ab"; feed 'A', 3 idle cycles, 'B' → no match; then 'A','b' → match.
- Reset and length limits:
  - feed "csco", assert `reset` for one edge, feed "re" → no match, `match_cnt=0`;
  - `len=0` with any stream → never match;
  - `cfg_len=MAXLEN+1` → ignored, old length still works.
- Config mid-stream: pattern "abc"; feed "ab", write `len_we` with len=3, feed "c" → no match (history cleared); a same-cycle `in_valid` 'z' is discarded.
- Counter: `CNT_W=2`, pattern "a"; feed 5 'a' → `match_cnt` saturates at 3. Assert `cnt_clr` with a hit in the same cycle → `match_cnt=0`, `match=1`.

Source files
------------

// File: rtl/pm_pkg.sv
// pm_pkg: shared types, ASCII constants and the case-folding helper used by
// the pattern_match datapath.
//   char_t     : one 8-bit ASCII character
//   fold_char  : maps 'A'..'Z' onto 'a'..'z' when case_ins is set
package pm_pkg;

    typedef logic [7:0] char_t;

    localparam char_t ASCII_UC_A     = 8'h41;
    localparam char_t ASCII_UC_Z     = 8'h5A;
    localparam char_t ASCII_CASE_OFF = 8'h20;

    function automatic char_t fold_char(char_t c, bit case_ins);
        if (case_ins && (c >= ASCII_UC_A) && (c <= ASCII_UC_Z))
            return c + ASCII_CASE_OFF;
        return c;
    endfunction

endpackage

// File: rtl/pm_compare.sv
// pm_compare: combinational occurrence detector.
//   hist_next_i : history after the current accept, index 0 = newest char
//   pat_i       : pattern, index 0 = first char of the pattern
//   len_i       : active pattern length (0 disables matching)
//   fill_next_i : number of valid history entries after the accept
//   hit_o       : the newest len_i history chars spell the pattern
module pm_compare
    import pm_pkg::*;
#(
    parameter int MAXLEN = 8
) (
    input  char_t [MAXLEN-1:0]          hist_next_i,
    input  char_t [MAXLEN-1:0]          pat_i,
    input  logic  [$clog2(MAXLEN+1)-1:0] len_i,
    input  logic  [$clog2(MAXLEN+1)-1:0] fill_next_i,
    output logic                        hit_o
);

    // eq[l] is true when the newest l characters match a pattern of length l.
    // Every candidate length is evaluated with constant indices, so len_i
    // only drives a final mux instead of a variable-index comparator.
    logic [MAXLEN:0] eq;

    always_comb begin
        eq = '0;
        for (int l = 1; l <= MAXLEN; l++) begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (hist_next_i[i] != pat_i[l-1-i])
                    ok = 1'b0;
            end
            eq[l] = ok;
        end
        hit_o = (len_i != '0) && (fill_next_i >= len_i) && eq[len_i];
    end

endmodule

// File: rtl/pattern_match.sv
// pattern_match: run-time programmable, optionally case-folding string
// detector. One character per in_valid cycle; match pulses one cycle after
// the character that completes an occurrence (overlaps included), and
// match_cnt keeps a saturating occurrence count.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, char      : input character stream
//   cfg_we/idx/char     : write one pattern slot
//   len_we, cfg_len     : load active pattern length (values > MAXLEN ignored)
//   cnt_clr             : clear match_cnt (wins over a same-cycle increment)
//   match, match_cnt    : registered hit pulse and occurrence count
module pattern_match
    import pm_pkg::*;
#(
    parameter int MAXLEN   = 8,
    parameter int CNT_W    = 16,
    parameter bit CASE_INS = 1'b1,
    localparam int IDX_W   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1,
    localparam int LEN_W   = $clog2(MAXLEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  char_t            char,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  char_t            cfg_char,
    input  logic             len_we,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    char_t [MAXLEN-1:0] pat_q;
    char_t [MAXLEN-1:0] hist_q, hist_d;
    logic  [LEN_W-1:0]  len_q;
    logic  [LEN_W-1:0]  fill_q, fill_d;
    logic               match_q;
    logic  [CNT_W-1:0]  cnt_q, cnt_d;

    logic len_ok, cfg_act, accept, cmp_hit, hit;

    // An out-of-range length write is not a config write at all, so it
    // neither clears history nor blocks a same-cycle character.
    assign len_ok  = len_we && (cfg_len <= LEN_W'(MAXLEN));
    assign cfg_act = cfg_we || len_ok;
    assign accept  = in_valid && !cfg_act;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (accept) begin
            hist_d[0] = fold_char(char, CASE_INS);
            for (int i = 1; i < MAXLEN; i++)
                hist_d[i] = hist_q[i-1];
            if (fill_q != LEN_W'(MAXLEN))
                fill_d = fill_q + LEN_W'(1);
        end
    end

    pm_compare #(.MAXLEN(MAXLEN)) u_cmp (
        .hist_next_i (hist_d),
        .pat_i       (pat_q),
        .len_i       (len_q),
        .fill_next_i (fill_d),
        .hit_o       (cmp_hit)
    );

    assign hit = accept && cmp_hit;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (hit && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= '0;
            hist_q  <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (cfg_act) begin
                // Pattern is stored pre-folded so the compare is a plain
                // byte equality.
                if (cfg_we && ({1'b0, cfg_idx} < (IDX_W+1)'(MAXLEN)))
                    pat_q[cfg_idx] <= fold_char(cfg_char, CASE_INS);
                if (len_ok)
                    len_q <= cfg_len;
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
            match_q <= hit;     // hit is 0 on config-write edges
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_match.sv
module tb_pattern_match;

    logic        clk = 1'b0;
    logic        reset, in_valid, cfg_we, len_we, cnt_clr;
    logic [7:0]  ch, cfg_char;
    logic [2:0]  cfg_idx;
    logic [3:0]  cfg_len;
    logic        m0, m1;
    logic [15:0] c0;
    logic [1:0]  c1;

    int tot = 0;
    int pass = 0;

    always #5 clk = ~clk;

    // u0: case-insensitive, wide counter. u1: exact compare, 2-bit counter.
    pattern_match #(.MAXLEN(8), .CNT_W(16), .CASE_INS(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
        .len_we(len_we), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
        .match(m0), .match_cnt(c0)
    );

    pattern_match #(.MAXLEN(8), .CNT_W(2), .CASE_INS(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_char(cfg_char),
        .len_we(len_we), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
        .match(m1), .match_cnt(c1)
    );

    typedef struct {
        string pat;
        int    len;
        string stream;   // '_' = idle cycle
        string exp;      // expected match after each step
        int    cnt;
        bit    sel;      // 0: check u0, 1: check u1
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        tot++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [7:0] c);
        in_valid = v;
        ch       = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; len_we = 1'b0; cnt_clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input string p, input int n);
        for (int i = 0; i < p.len(); i++) begin
            cfg_we   = 1'b1;
            cfg_idx  = 3'(i);
            cfg_char = p[i];
            tick();
        end
        cfg_we  = 1'b0;
        len_we  = 1'b1;
        cfg_len = 4'(n);
        tick();
        len_we  = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int act;
        reset = 1'b0; in_valid = 1'b0; ch = 8'h00; cfg_we = 1'b0; cfg_idx = '0;
        cfg_char = 8'h00; len_we = 1'b0; cfg_len = '0; cnt_clr = 1'b0;

        tbl[0] = '{"csCore",   6, "xCSCORE",   "0000001",   1, 1'b0};
        tbl[1] = '{"aba",      3, "ababa",     "00101",     2, 1'b0};
        tbl[2] = '{"aa",       2, "aaa",       "011",       2, 1'b0};
        tbl[3] = '{"a",        0, "aaaa",      "0000",      0, 1'b0};
        tbl[4] = '{"ab",       2, "a__B_",     "00010",     1, 1'b0};
        tbl[5] = '{"@[",       2, "`{@[",      "0001",      1, 1'b0};
        tbl[6] = '{"abcdefgh", 8, "xabcdefgh", "000000001", 1, 1'b0};
        tbl[7] = '{"Ab",       2, "A___BAb",   "0000001",   1, 1'b1};
        tbl[8] = '{"a",        1, "aaaaa",     "11111",     3, 1'b1};

        do_reset();
        chk("reset u0 match", int'(m0), 0);
        chk("reset u0 cnt",   int'(c0), 0);
        chk("reset u1 match", int'(m1), 0);
        chk("reset u1 cnt",   int'(c1), 0);

        foreach (tbl[t]) begin
            do_reset();
            load(tbl[t].pat, tbl[t].len);
            for (int j = 0; j < tbl[t].stream.len(); j++) begin
                c = tbl[t].stream[j];
                step(c != 8'h5F, c);
                act = tbl[t].sel ? int'(m1) : int'(m0);
                chk($sformatf("%s step%0d match", tbl[t].pat, j), act,
                    (tbl[t].exp[j] == 8'h31) ? 1 : 0);
            end
            act = tbl[t].sel ? int'(c1) : int'(c0);
            chk($sformatf("%s cnt", tbl[t].pat), act, tbl[t].cnt);
        end

        // Reset mid-stream discards the partial occurrence (and the config).
        do_reset();
        load("csCore", 6);
        step(1'b1, "c"); step(1'b1, "s"); step(1'b1, "c"); step(1'b1, "o");
        do_reset();
        step(1'b1, "r");
        chk("midreset r match", int'(m0), 0);
        step(1'b1, "e");
        chk("midreset e match", int'(m0), 0);
        chk("midreset cnt", int'(c0), 0);

        // Out-of-range length write is ignored, same-cycle char still accepted.
        do_reset();
        load("ab", 2);
        step(1'b1, "a");
        len_we = 1'b1; cfg_len = 4'd9;
        step(1'b1, "b");
        len_we = 1'b0;
        chk("badlen match", int'(m0), 1);
        step(1'b1, "a"); step(1'b1, "b");
        chk("badlen oldlen match", int'(m0), 1);
        chk("badlen cnt", int'(c0), 2);

        // Config mid-stream clears history; same-cycle char discarded.
        do_reset();
        load("abc", 3);
        step(1'b1, "a"); step(1'b1, "b");
        len_we = 1'b1; cfg_len = 4'd3;
        step(1'b1, "z");
        len_we = 1'b0;
        chk("cfgmid z match", int'(m0), 0);
        step(1'b1, "c");
        chk("cfgmid c match", int'(m0), 0);
        step(1'b1, "a"); step(1'b1, "b"); step(1'b1, "c");
        chk("cfgmid abc match", int'(m0), 1);

        do_reset();
        load("ab", 2);
        len_we = 1'b1; cfg_len = 4'd2;
        step(1'b1, "a");
        len_we = 1'b0;
        step(1'b1, "b");
        chk("cfgdiscard b match", int'(m0), 0);

        // Counter saturation then clear with a same-cycle hit.
        do_reset();
        load("a", 1);
        step(1'b1, "a"); step(1'b1, "a"); step(1'b1, "a"); step(1'b1, "a");
        chk("sat u1 cnt", int'(c1), 3);
        cnt_clr = 1'b1;
        step(1'b1, "a");
        cnt_clr = 1'b0;
        chk("clr u1 match", int'(m1), 1);
        chk("clr u1 cnt",   int'(c1), 0);
        chk("clr u0 match", int'(m0), 1);
        chk("clr u0 cnt",   int'(c0), 0);
        step(1'b0, 8'h00);
        chk("idle u0 match", int'(m0), 0);
        step(1'b1, "A");
        chk("after clr u0 cnt", int'(c0), 1);
        chk("exact u1 A match", int'(m1), 0);

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end

endmodule
